// File: rtl/req_latch_if.sv
// -----------------------------------------------------------------------------
// req_latch_if
// Purpose : bundles the request-conditioning bus between the raw request
//           source / consumer (master) and the req_latch stage (slave).
// Signals : req_in   - raw asynchronous request lines
//           ack_vld  - consumer serviced index ack_idx this cycle
//           ack_idx  - encoded index being acknowledged
//           ovf_clr  - clears all sticky overflow flags
//           mask     - per-line presentation mask (only with REQ_MASK_EN)
//           pend     - pending vector toward the priority encoder
//           any_pend - OR of pend
//           ovf      - sticky per-line overflow flags
// Config  : REQ_MASK_EN adds the mask signal to both modports.
// -----------------------------------------------------------------------------
interface req_latch_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  req_in;
    logic          ack_vld;
    logic [IW-1:0] ack_idx;
    logic          ovf_clr;
`ifdef REQ_MASK_EN
    logic [N-1:0]  mask;
`endif
    logic [N-1:0]  pend;
    logic          any_pend;
    logic [N-1:0]  ovf;

`ifdef REQ_MASK_EN
    modport master (
        output req_in, ack_vld, ack_idx, ovf_clr, mask,
        input  pend, any_pend, ovf
    );

    modport slave (
        input  req_in, ack_vld, ack_idx, ovf_clr, mask,
        output pend, any_pend, ovf
    );
`else
    modport master (
        output req_in, ack_vld, ack_idx, ovf_clr,
        input  pend, any_pend, ovf
    );

    modport slave (
        input  req_in, ack_vld, ack_idx, ovf_clr,
        output pend, any_pend, ovf
    );
`endif

endinterface

// File: rtl/req_latch.sv
// -----------------------------------------------------------------------------
// req_latch
// Purpose : synchronises raw asynchronous request lines, detects rising edges
//           and holds each one as a sticky pending bit until the consumer
//           acknowledges its index. A second edge on a still-pending line
//           raises a sticky overflow flag.
// Ports   : clk    - rising-edge clock, sole domain
//           rst_n  - asynchronous active-low reset
//           bus    - req_latch_if.slave (req_in, ack_vld, ack_idx, ovf_clr,
//                    [mask], pend, any_pend, ovf)
// Config  : REQ_MASK_EN - when defined, pend/any_pend are gated by bus.mask;
//           masked lines still latch events, flag overflow and accept acks.
// -----------------------------------------------------------------------------
module req_latch #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    req_latch_if.slave  bus
);

    localparam int unsigned IW = $clog2(N);

    // Synchroniser chain: index 0 samples the raw line, top index is the
    // clean synchronised level.
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [SYNC_STAGES-1:0][N-1:0] sync_d;
    logic [N-1:0]                  s_d_q;
    logic [N-1:0]                  p_q;
    logic [N-1:0]                  p_d;
    logic [N-1:0]                  ovf_q;
    logic [N-1:0]                  ovf_d;

    logic [N-1:0]                  sync_lvl;
    logic [N-1:0]                  rise;
    logic [N-1:0]                  clr;
    logic [N-1:0]                  pend_c;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~s_d_q;

    // One-hot decode of the acknowledged index.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            clr[i] = bus.ack_vld && (bus.ack_idx == IW'(i));
        end
    end

    // Next-state: a new edge always wins over a same-cycle clear so no event
    // is lost; overflow set wins over ovf_clr.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.req_in};
        p_d    = rise | (p_q & ~clr);
        ovf_d  = (bus.ovf_clr ? '0 : ovf_q) | (rise & p_q & ~clr);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= '0;
            p_q    <= '0;
            ovf_q  <= '0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= sync_lvl;
            p_q    <= p_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef REQ_MASK_EN
    assign pend_c = p_q & ~bus.mask;
`else
    assign pend_c = p_q;
`endif

    assign bus.pend     = pend_c;
    assign bus.any_pend = |pend_c;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_req_latch.sv
// -----------------------------------------------------------------------------
// tb_req_latch
// Self-checking bench for req_latch: an event-level reference model is
// compared against the DUT on every falling edge, plus literal expectations
// for the directed scenarios, then a randomized phase with occasional
// asynchronous resets.
// -----------------------------------------------------------------------------
module tb_req_latch;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    req_latch_if #(.N(N)) bus_if ();

    req_latch #(
        .N           (N),
        .SYNC_STAGES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Reference model: history of sampled request levels; an event is
    // registered at an edge when the level seen S edges back is high and the
    // level one edge before that was low.
    logic [S:0][N-1:0] m_hist;
    logic [N-1:0]      m_p;
    logic [N-1:0]      m_ovf;
    logic [N-1:0]      m_ev;
    logic [N-1:0]      m_ack;

    assign m_ev = m_hist[S-1] & ~m_hist[S];

    always_comb begin
        m_ack = '0;
        if (bus_if.ack_vld) m_ack[bus_if.ack_idx] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist <= '0;
            m_p    <= '0;
            m_ovf  <= '0;
        end else begin
            m_hist <= {m_hist[S-1:0], bus_if.req_in};
            if (bus_if.ovf_clr) m_ovf <= '0;
            for (int i = 0; i < int'(N); i++) begin
                if (m_ev[i]) begin
                    m_p[i] <= 1'b1;
                    if (m_p[i] && !m_ack[i]) m_ovf[i] <= 1'b1;
                end else if (m_ack[i]) begin
                    m_p[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [N-1:0] exp_pend();
`ifdef REQ_MASK_EN
        return m_p & ~bus_if.mask;
`else
        return m_p;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("model_pend",     32'(bus_if.pend),     32'(exp_pend()));
        chk("model_any_pend", 32'(bus_if.any_pend), 32'(|exp_pend()));
        chk("model_ovf",      32'(bus_if.ovf),      32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_cmp();
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic ack(input int idx);
        bus_if.ack_vld = 1'b1;
        bus_if.ack_idx = IW'(idx);
        tick();
        bus_if.ack_vld = 1'b0;
    endtask

    task automatic pulse_twice(input int line);
        bus_if.req_in[line] = 1'b1; tick_n(3);
        bus_if.req_in[line] = 1'b0; tick_n(3);
        bus_if.req_in[line] = 1'b1; tick_n(3);
        bus_if.req_in[line] = 1'b0; tick_n(3);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.req_in  = 4'b1111;
        bus_if.ack_vld = 1'b0;
        bus_if.ack_idx = '0;
        bus_if.ovf_clr = 1'b0;
`ifdef REQ_MASK_EN
        bus_if.mask    = '0;
`endif

        // Reset with all lines high; one event per line after release.
        tick_n(2);
        chk("rst_pend", 32'(bus_if.pend), 32'h0);
        chk("rst_ovf",  32'(bus_if.ovf),  32'h0);
        rst_n = 1'b1;
        tick_n(2);
        chk("rel_pend_early", 32'(bus_if.pend), 32'h0);
        tick();
        chk("rel_pend",     32'(bus_if.pend),     32'hF);
        chk("rel_any_pend", 32'(bus_if.any_pend), 32'h1);
        chk("rel_ovf",      32'(bus_if.ovf),      32'h0);
        for (int i = 0; i < int'(N); i++) ack(i);
        tick_n(2);
        chk("level_no_event", 32'(bus_if.pend), 32'h0);
        bus_if.req_in = '0;
        tick_n(3);

        // Latency and ack of line 2.
        bus_if.req_in[2] = 1'b1;
        tick_n(2);
        chk("lat_pend_early", 32'(bus_if.pend), 32'h0);
        tick();
        chk("lat_pend", 32'(bus_if.pend), 32'h4);
        tick_n(2);
        ack(2);
        chk("ack_pend", 32'(bus_if.pend), 32'h0);
        tick_n(3);
        chk("ack_no_reassert", 32'(bus_if.pend), 32'h0);
        bus_if.req_in[2] = 1'b0;
        tick_n(3);

        // New edge on line 1 coincident with its ack.
        bus_if.req_in[1] = 1'b1; tick_n(3);
        chk("sim_pend_before", 32'(bus_if.pend), 32'h2);
        bus_if.req_in[1] = 1'b0; tick_n(2);
        bus_if.req_in[1] = 1'b1; tick_n(2);
        ack(1);
        chk("sim_pend", 32'(bus_if.pend), 32'h2);
        chk("sim_ovf",  32'(bus_if.ovf),  32'h0);
        ack(1);
        chk("sim_pend_cleared", 32'(bus_if.pend), 32'h0);
        bus_if.req_in[1] = 1'b0;
        tick_n(3);

        // Overflow on line 0, then ovf_clr.
        pulse_twice(0);
        chk("ovf_pend", 32'(bus_if.pend), 32'h1);
        chk("ovf_ovf",  32'(bus_if.ovf),  32'h1);
        bus_if.ovf_clr = 1'b1; tick();
        bus_if.ovf_clr = 1'b0;
        chk("ovfclr_ovf",  32'(bus_if.ovf),  32'h0);
        chk("ovfclr_pend", 32'(bus_if.pend), 32'h1);
        ack(0);
        chk("ovf_ack_pend", 32'(bus_if.pend), 32'h0);

        // Stray ack to a line with nothing pending.
        bus_if.req_in[3] = 1'b1; tick_n(3);
        bus_if.req_in[3] = 1'b0;
        chk("stray_pre", 32'(bus_if.pend), 32'h8);
        ack(0);
        chk("stray_pend", 32'(bus_if.pend), 32'h8);

        // Asynchronous reset between edges.
        pulse_twice(1);
        chk("mid_pend", 32'(bus_if.pend), 32'hA);
        chk("mid_ovf",  32'(bus_if.ovf),  32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pend",     32'(bus_if.pend),     32'h0);
        chk("async_any_pend", 32'(bus_if.any_pend), 32'h0);
        chk("async_ovf",      32'(bus_if.ovf),      32'h0);
        tick();
        rst_n = 1'b1;
        tick_n(3);

`ifdef REQ_MASK_EN
        // Masked line latches but is hidden until unmasked.
        bus_if.mask      = 4'b0100;
        bus_if.req_in[2] = 1'b1; tick_n(4);
        chk("mask_pend", 32'(bus_if.pend),     32'h0);
        chk("mask_any",  32'(bus_if.any_pend), 32'h0);
        bus_if.req_in[2] = 1'b0;
        bus_if.mask      = '0;
        #1;
        chk("unmask_pend", 32'(bus_if.pend),     32'h4);
        chk("unmask_any",  32'(bus_if.any_pend), 32'h1);
        ack(2);
        tick_n(2);
`endif

        // Randomized phase against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(3) == 0) bus_if.req_in[i] = ~bus_if.req_in[i];
            end
            bus_if.ack_vld = ($urandom_range(2) == 0);
            bus_if.ack_idx = IW'($urandom_range(N - 1));
            bus_if.ovf_clr = ($urandom_range(7) == 0);
`ifdef REQ_MASK_EN
            if ($urandom_range(9) == 0) bus_if.mask = N'($urandom_range(15));
`endif
            if ((c % 150) == 149) begin
                #2 rst_n = 1'b0;
                #1 model_cmp();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_latch.md
# req_latch

Request-conditioning stage that sits directly upstream of the 4-input priority encoder. It synchronises raw, asynchronous request lines into the `clk` domain and detects their rising edges. Each edge is latched as a sticky pending bit, and the registered pending vector is presented to the encoder's `D` input. A pending bit is held until the consumer acknowledges the encoded index.

## Interface
- `N`, 4, number of request lines; power of two, ≥ 2.
- `SYNC_STAGES`, 2, synchroniser depth per line; ≥ 2.
- `IW`, `$clog2(N)`, index width; derived, not overridden.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_in`  in  N  raw request lines, asynchronous to `clk`; events are rising edges.
- `ack_vld`  in  1  consumer has serviced index `ack_idx` this cycle.
- `ack_idx`  in  IW  index being acknowledged (encoder `Y` value).
- `ovf_clr`  in  1  clears all sticky overflow bits.
- `pend`  out  N  registered pending vector; drives encoder `D`.
- `any_pend`  out  1  OR-reduction of `pend` (combinational from registers).
- `ovf`  out  N  sticky per-line overflow flags.

## Operation
- Per line: SYNC_STAGES-flop chain → `s`; delay flop `s_d`; `rise[i] = s[i] & ~s_d[i]`.
- Pending register `p[i]` next state is `rise[i] | (p[i] & ~clr[i])`.
  - `clr[i] = ack_vld & (ack_idx == i)`.
  - A new edge coincident with a clear of the same line leaves the bit set; the new event is not lost.
- Ack to a line whose `p` is 0 has no effect and no error.
- Only one line can be cleared per cycle.
- Overflow: `ovf[i]` sets when `rise[i] & p[i] & ~clr[i]`, i.e. a second edge arrives while still pending.
  - The event count collapses to one pending bit.
  - `ovf_clr` clears all bits next edge.
  - If `ovf_clr` and a new overflow condition occur in the same cycle, set wins.
- Levels are not events: a line held high produces exactly one pending event.
- Reset: all sync flops, `s_d`, `p` and `ovf` are cleared asynchronously.
  - `pend`, `any_pend` and `ovf` read 0 during and immediately after reset.
  - A line high across reset release produces one event (sync rises from 0).
- Reset mid-operation discards all pending events and overflow flags; no partial state survives.

## Timing
- `req_in` rising before edge k → `s` high after edge k+SYNC_STAGES−1 → `pend[i]` high after edge k+SYNC_STAGES (default: 3 edges incl. k).
- `ack_vld` sampled at edge k → `pend[i]` low after edge k (1-cycle clear), unless re-set by `rise`.
- Minimum `req_in` high and low pulse widths are each ≥ 1 `clk` period plus sync setup margin for guaranteed detection; narrower pulses may be missed.
- Overflow: `ovf[i]` visible after the same edge at which the second `rise` is registered.
- `any_pend` settles in the same cycle as `pend`; no additional latency.
- No handshake stalls; the block never back-pressures the consumer.

## Configuration
- `REQ_MASK_EN` defined:
  - Adds input `mask` [N-1:0].
  - `pend = p & ~mask`; `any_pend` follows the masked vector.
  - Masked lines still latch events and flag overflow, and appear on `pend` once unmasked.
  - Acks to masked lines still clear `p`.
- `REQ_MASK_EN` undefined: no `mask` port; `pend = p`.

## Test plan
- Reset: hold `rst_n`=0 with `req_in`=4'b1111, release → `pend`=0 for SYNC_STAGES edges, then 4'b1111; `ovf`=0.
- Latency/ack: raise `req_in[2]` before edge 0, hold high → `pend`=4'b0100 after edge 2; `ack_vld`=1, `ack_idx`=2 at edge 5 → `pend`=0 after edge 5; no re-assertion while the line stays high.
- Simultaneous set/clear: `p[1]`=1, new edge on line 1 reaches `rise` in the same cycle as ack idx 1 → `pend[1]` stays 1 and `ovf[1]` stays 0.
- Overflow: pulse line 0 twice (3-cycle pulses, 3-cycle gap) with no ack → `pend`=4'b0001 and `ovf`=4'b0001; `ovf_clr` → `ovf`=0 and `pend` unchanged.
- Stray ack: `pend`=4'b1000, ack idx 0 → `pend` stays 4'b1000.
- Async reset mid-operation: `pend`=4'b1010, `ovf`=4'b0010, drop `rst_n` between edges → `pend` and `ovf` are 0 immediately, without waiting for a clock edge.
- Mask (with `REQ_MASK_EN`): `mask`=4'b0100, edge on line 2 → `pend`=0 and `any_pend`=0; clear mask → `pend`=4'b0100.
